w_stream_tx: RTL and testbench
==============================

# w_stream_tx

Weight-stream transmitter on the 100 MHz side of the weight path. It accepts one layer command at a time and reads the layer's weight words from the weight source memory. It emits them as a 128-bit valid/ready stream: one header beat followed by the payload beats, into the weight-control/RAM-fill path. A small credit-managed FIFO absorbs the memory read latency and downstream backpressure without losing data.

## Interface
- ADDR_W, 16: weight source memory word-address width.
- RD_LAT, 2: fixed memory read latency in cycles (≥1).
- FIFO_DEPTH, 8: output buffer entries (power of two, ≥ RD_LAT+2).
- clk_100M  in  1  block clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_vld  in  1  layer command valid.
- cmd_rdy  out  1  block can accept a command.
- cmd_base_addr  in  ADDR_W  first memory word address.
- cmd_beats  in  14  payload beat count (0..9216).
- cmd_rd_len  in  11  per-layer read-cycle count, carried in header.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  128  read data, valid exactly RD_LAT cycles after mem_rd_en.
- w_in_vld  out  1  stream beat valid.
- w_in  out  128  stream beat.
- w_in_rdy  in  1  downstream accepts beat.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse, last beat of command accepted downstream.

## Operation
- States: IDLE, HDR, FETCH, DRAIN. cmd_rdy = (state==IDLE).
- IDLE: on cmd_vld&cmd_rdy latch base, beats, rd_len, then go to HDR.
- HDR: when credit available, write header to FIFO, then go to FETCH (to DRAIN if beats==0).
- Header fields: [127:120]=8'hA5 sync, [119:106]=beats, [10:0]=rd_len, all other bits 0.
- FETCH: each cycle with credit, assert mem_rd_en, drive addr = base+issued (mod 2^ADDR_W), and increment issued. When issued==beats after the issue, go to DRAIN.
- Credit: fifo_count + inflight < FIFO_DEPTH, using registered counts. A pop in the same cycle is credited the next cycle.
- Return path: RD_LAT-deep valid shift register. Data is written to the FIFO on the cycle its valid emerges. Credit guarantees no overflow.
- Output: show-ahead FIFO head. w_in_vld = FIFO non-empty. A beat transfers on w_in_vld&w_in_rdy.
- DRAIN: when inflight==0 and the FIFO pops its last entry, pulse done and go to IDLE. busy = state!=IDLE.
- w_in is held stable while w_in_vld&!w_in_rdy.
- Reset mid-command: state IDLE, counters and FIFO cleared, in-flight return data discarded. No partial stream resumes.

## Timing
- Reset values: cmd_rdy=1, mem_rd_en=0, mem_rd_addr=0, w_in_vld=0, w_in=0, busy=0, done=0.
- Cycle T is the command handshake.
  - T+1: state HDR, header written.
  - T+2: header on w_in with w_in_vld=1, and first mem_rd_en with addr=base.
  - T+2+RD_LAT: first payload written to the FIFO.
  - Earliest first payload on w_in: T+3+RD_LAT.
- Sustained throughput is 1 beat/cycle with w_in_rdy held high.
- done is asserted in the cycle after the final handshake. cmd_rdy rises in the same cycle as done.
- Back-to-back commands: the next handshake is possible in the cycle cmd_rdy=1. The next header follows with no extra gap.

## Structure
- Package w_stream_pkg holds:
  - state enum;
  - HDR_SYNC=8'hA5;
  - header field bit positions;
  - beat width 128.
- Sub-module w_tx_fifo: synchronous show-ahead FIFO (DEPTH, WIDTH params) with count output.
- The top contains the FSM, issue counter, address generator, latency shift register and credit logic.

## Test plan
- beats=4, base=0x0010, rd_len=35, rdy=1: header {A5,4,…,35} then data of addrs 0x10..0x13 on consecutive cycles; done at last+1.
- beats=0: exactly one header beat, zero mem_rd_en, done one cycle after the header handshake.
- Backpressure:
  - Stimulus: beats=36, w_in_rdy toggling at random with a 20-cycle low stall.
  - Response: all 37 beats in order, none dropped or duplicated.
  - During the stall, fifo_count+inflight stays ≤ FIFO_DEPTH and mem_rd_en stops.
- base=0xFFFE, beats=4: addresses FFFE, FFFF, 0000, 0001.
- rst_n asserted mid-FETCH with reads in flight: the next cycle has all outputs at reset values. Late mem data is ignored, and a new command streams cleanly.
- Two back-to-back commands (beats 3 and 5): second header immediately follows the first payload tail; two done pulses.

Source files
------------

// File: rtl/w_stream_pkg.sv
// Shared types and header layout for the weight-stream transmitter.
// The stream carries one header beat, then the layer's payload beats.
package w_stream_pkg;

    localparam int BEAT_W = 128;
    localparam int BEATS_W = 14;
    localparam int RD_LEN_W = 11;

    localparam logic [7:0] HDR_SYNC = 8'hA5;
    localparam int HDR_SYNC_LSB = 120;
    localparam int HDR_BEATS_LSB = 106;
    localparam int HDR_RD_LEN_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    function automatic logic [BEAT_W-1:0] make_header(
        input logic [BEATS_W-1:0] beats,
        input logic [RD_LEN_W-1:0] rd_len
    );
        logic [BEAT_W-1:0] h;
        h = '0;
        h[HDR_SYNC_LSB +: 8] = HDR_SYNC;
        h[HDR_BEATS_LSB +: BEATS_W] = beats;
        h[HDR_RD_LEN_LSB +: RD_LEN_W] = rd_len;
        return h;
    endfunction

endpackage

// File: rtl/w_tx_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data while
// the FIFO is non-empty, and reads as zero while it is empty.
module w_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 128
) (
    input  logic                           clk_100M,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_rd;

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    // NOTE: the storage array has no reset; the pointers and count alone decide validity.
    always_ff @(posedge clk_100M) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, do_rd})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/w_stream_tx.sv
// Weight-stream transmitter: turns one layer command into a header beat plus
// payload beats read from memory, buffered through a credit-managed FIFO.
module w_stream_tx
    import w_stream_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk_100M,
    input  logic                rst_n,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic [ADDR_W-1:0]   cmd_base_addr,
    input  logic [BEATS_W-1:0]  cmd_beats,
    input  logic [RD_LEN_W-1:0] cmd_rd_len,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [BEAT_W-1:0]   mem_rd_data,
    output logic                w_in_vld,
    output logic [BEAT_W-1:0]   w_in,
    input  logic                w_in_rdy,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0]   base_q;
    logic [BEATS_W-1:0]  beats_q;
    logic [BEATS_W-1:0]  issued_q;
    logic [RD_LEN_W-1:0] rd_len_q;
    logic [RD_LAT-1:0]   vld_sr_q;
    logic [CNT_W-1:0]    inflight_q;
    logic [CNT_W-1:0]    fifo_count;

    logic              fifo_empty;
    logic              fifo_wr;
    logic [BEAT_W-1:0] fifo_wr_data;
    logic              credit;
    logic              hdr_wr;
    logic              ret_vld;
    logic              pop;
    logic              cmd_acc;
    logic              last_issue;
    logic              last_pop;

    // Credit counts both buffered beats and reads whose data is still in the memory pipe.
    assign credit     = ({1'b0, fifo_count} + {1'b0, inflight_q}) < DEPTH_C;
    assign ret_vld    = vld_sr_q[RD_LAT-1];
    assign w_in_vld   = ~fifo_empty;
    assign pop        = w_in_vld & w_in_rdy;
    assign cmd_acc    = cmd_vld & cmd_rdy;
    assign last_issue = (issued_q + BEATS_W'(1)) == beats_q;
    assign last_pop   = pop && (fifo_count == CNT_W'(1)) && (inflight_q == '0);

    assign mem_rd_addr  = base_q + ADDR_W'(issued_q);
    assign fifo_wr      = hdr_wr | ret_vld;
    assign fifo_wr_data = hdr_wr ? make_header(beats_q, rd_len_q) : mem_rd_data;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_vld) state_d = ST_HDR;
            ST_HDR:   if (credit) state_d = (beats_q == '0) ? ST_DRAIN : ST_FETCH;
            ST_FETCH: if (credit && last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (last_pop) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_rdy   = 1'b0;
        busy      = 1'b1;
        mem_rd_en = 1'b0;
        hdr_wr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_rdy = 1'b1;
                busy    = 1'b0;
            end
            ST_HDR:   hdr_wr    = credit;
            ST_FETCH: mem_rd_en = credit;
            default:  ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            beats_q    <= '0;
            issued_q   <= '0;
            rd_len_q   <= '0;
            vld_sr_q   <= '0;
            inflight_q <= '0;
            done       <= 1'b0;
        end else begin
            if (cmd_acc) begin
                base_q   <= cmd_base_addr;
                beats_q  <= cmd_beats;
                rd_len_q <= cmd_rd_len;
                issued_q <= '0;
            end else if (mem_rd_en) begin
                issued_q <= issued_q + BEATS_W'(1);
            end

            vld_sr_q[0] <= mem_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr_q[i] <= vld_sr_q[i-1];
            end

            case ({mem_rd_en, ret_vld})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase

            done <= (state_q == ST_DRAIN) && last_pop;
        end
    end

    w_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .wr_en    (fifo_wr),
        .wr_data  (fifo_wr_data),
        .rd_en    (pop),
        .rd_data  (w_in),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_w_stream_tx.sv
// Scoreboard bench for w_stream_tx: a queue-based stream model plus a
// latency-pipe memory model, with random backpressure and a mid-command reset.
module tb_w_stream_tx;

    localparam int ADDR_W     = 16;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 8;

    logic          clk_100M = 1'b0;
    logic          rst_n    = 1'b0;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [15:0]   cmd_base_addr;
    logic [13:0]   cmd_beats;
    logic [10:0]   cmd_rd_len;
    logic          mem_rd_en;
    logic [15:0]   mem_rd_addr;
    logic [127:0]  mem_rd_data;
    logic          w_in_vld;
    logic [127:0]  w_in;
    logic          w_in_rdy;
    logic          busy;
    logic          done;

    typedef struct {
        logic [127:0] data;
        bit           is_hdr;
        bit           last;
    } exp_t;

    exp_t         exp_q[$];
    int           cmd_q[$];
    int           acc_cyc[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           rd_cnt = 0;
    int           reads_out = 0;
    int           done_total = 0;
    int           stall_cnt = 0;
    int           rdy_mode = 0;
    bit           stall_on = 1'b0;
    bit           done_pend = 1'b0;
    bit           hold_vld = 1'b0;
    logic [127:0] hold_data = '0;
    logic [15:0]  addr_pipe [RD_LAT];

    w_stream_tx #(
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_100M      (clk_100M),
        .rst_n         (rst_n),
        .cmd_vld       (cmd_vld),
        .cmd_rdy       (cmd_rdy),
        .cmd_base_addr (cmd_base_addr),
        .cmd_beats     (cmd_beats),
        .cmd_rd_len    (cmd_rd_len),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .w_in_vld      (w_in_vld),
        .w_in          (w_in),
        .w_in_rdy      (w_in_rdy),
        .busy          (busy),
        .done          (done)
    );

    initial forever #5 clk_100M = ~clk_100M;

    always @(posedge clk_100M) cyc <= cyc + 1;

    // Deterministic memory contents: every address has a distinct word.
    function automatic logic [127:0] mem_word(input logic [15:0] a);
        logic [31:0] x;
        x = {16'h0, a} * 32'h9E37_79B1;
        return {a, ~a, x, ~x ^ 32'h5A5A_5A5A, a ^ 16'h1234, a};
    endfunction

    // Memory with a fixed read latency; it keeps returning data through reset.
    always @(posedge clk_100M) begin
        addr_pipe[0] <= mem_rd_en ? mem_rd_addr : 16'hBEEF;
        for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    end
    assign mem_rd_data = mem_word(addr_pipe[RD_LAT-1]);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready: always high, random, or forced low during a stall window.
    initial begin
        w_in_rdy = 1'b1;
        forever begin
            @(posedge clk_100M);
            #1;
            if (stall_cnt > 0) begin
                w_in_rdy = 1'b0;
                stall_on = 1'b1;
                stall_cnt--;
            end else begin
                stall_on = 1'b0;
                w_in_rdy = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks done/stability/credit.
    always @(negedge clk_100M) begin
        if (rst_n) begin
            if (done_pend || done) begin
                check_int("done_pulse", int'(done), int'(done_pend));
            end
            if (done) begin
                done_total++;
                if (cmd_q.size() > 0) begin
                    check_int("reads_per_cmd", rd_cnt, cmd_q.pop_front());
                end else begin
                    check_int("done_without_cmd", 0, 1);
                end
                rd_cnt = 0;
            end
            done_pend = 1'b0;

            if (mem_rd_en) begin
                rd_cnt++;
                reads_out++;
            end

            if (hold_vld) begin
                check_int("stall_vld_held", int'(w_in_vld), 1);
                check("stall_data_held", w_in, hold_data);
            end

            if (w_in_vld && w_in_rdy) begin
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none (cycle %0d)", w_in, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat", w_in, e.data);
                    if (!e.is_hdr) reads_out--;
                    if (e.last) done_pend = 1'b1;
                end
            end
            hold_vld  = w_in_vld && !w_in_rdy;
            hold_data = w_in;

            if (stall_on) begin
                check_int("stall_credit_bound", int'(reads_out <= FIFO_DEPTH), 1);
                if (stall_cnt == 0) check_int("stall_rd_stopped", int'(mem_rd_en), 0);
            end
        end
    end

    task automatic flush_sb();
        exp_q.delete();
        cmd_q.delete();
        acc_cyc.delete();
        rd_cnt    = 0;
        reads_out = 0;
        done_pend = 1'b0;
        hold_vld  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_int({tag, "_cmd_rdy"}, int'(cmd_rdy), 1);
        check_int({tag, "_mem_rd_en"}, int'(mem_rd_en), 0);
        check_int({tag, "_mem_rd_addr"}, int'(mem_rd_addr), 0);
        check_int({tag, "_w_in_vld"}, int'(w_in_vld), 0);
        check({tag, "_w_in"}, w_in, '0);
        check_int({tag, "_busy"}, int'(busy), 0);
        check_int({tag, "_done"}, int'(done), 0);
    endtask

    // Issue one command; the expected stream is queued from the command fields alone.
    task automatic send_cmd(input logic [15:0] base, input int beats, input logic [10:0] rd_len,
                            output int t_hs);
        int   budget;
        exp_t e;
        budget = 0;
        @(negedge clk_100M);
        cmd_vld       = 1'b1;
        cmd_base_addr = base;
        cmd_beats     = 14'(beats);
        cmd_rd_len    = rd_len;
        while (!cmd_rdy && budget < 5000) begin
            @(negedge clk_100M);
            budget++;
        end
        check_int("cmd_rdy_wait", int'(cmd_rdy), 1);
        t_hs = cyc;
        e.data   = {8'hA5, 14'(beats), 95'b0, rd_len};
        e.is_hdr = 1'b1;
        e.last   = (beats == 0);
        exp_q.push_back(e);
        for (int i = 0; i < beats; i++) begin
            e.data   = mem_word(16'(base + 16'(i)));
            e.is_hdr = 1'b0;
            e.last   = (i == beats - 1);
            exp_q.push_back(e);
        end
        cmd_q.push_back(beats);
        @(posedge clk_100M);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0) && i < budget) begin
            @(negedge clk_100M);
            i++;
        end
        check_int({name, "_drained"}, exp_q.size() + cmd_q.size(), 0);
        @(negedge clk_100M);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t1;
        int d0;
        cmd_vld       = 1'b0;
        cmd_base_addr = '0;
        cmd_beats     = '0;
        cmd_rd_len    = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk_100M);
        check_reset_outputs("rst_init");
        rst_n = 1'b1;

        // Basic stream with full-rate downstream and exact latency checks.
        rdy_mode = 0;
        acc_cyc.delete();
        d0 = done_total;
        send_cmd(16'h0010, 4, 11'd35, t0);
        wait_idle("basic", 200);
        check_int("basic_beat_count", acc_cyc.size(), 5);
        if (acc_cyc.size() == 5) begin
            check_int("basic_hdr_cycle", acc_cyc[0], t0 + 2);
            for (int i = 1; i < 5; i++) check_int("basic_payload_cycle", acc_cyc[i], t0 + 2 + RD_LAT + i);
        end
        check_int("basic_done_count", done_total - d0, 1);

        // Zero-beat command: header only, no reads.
        acc_cyc.delete();
        d0 = done_total;
        send_cmd(16'h1234, 0, 11'd7, t0);
        wait_idle("zero", 200);
        check_int("zero_beat_count", acc_cyc.size(), 1);
        if (acc_cyc.size() == 1) check_int("zero_hdr_cycle", acc_cyc[0], t0 + 2);
        check_int("zero_done_count", done_total - d0, 1);

        // Address wrap at the top of the memory.
        rdy_mode = 1;
        send_cmd(16'hFFFE, 4, 11'd2047, t0);
        wait_idle("wrap", 400);

        // Backpressure with random ready and a 20-cycle stall.
        acc_cyc.delete();
        send_cmd(16'h0400, 36, 11'd100, t0);
        repeat (8) @(negedge clk_100M);
        stall_cnt = 20;
        wait_idle("stall", 3000);
        check_int("stall_beat_count", acc_cyc.size(), 37);

        // Reset in the middle of a fetch with reads still in flight.
        rdy_mode = 0;
        send_cmd(16'h0800, 20, 11'd5, t0);
        repeat (3) @(negedge clk_100M);
        rst_n = 1'b0;
        #1;
        flush_sb();
        check_reset_outputs("rst_mid");
        @(negedge clk_100M);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_100M);
            check_int("rst_no_stale_beat", int'(w_in_vld), 0);
        end
        rdy_mode = 1;
        send_cmd(16'h0200, 6, 11'd9, t0);
        wait_idle("after_rst", 400);

        // Back-to-back commands: the second handshake lands in the done cycle.
        rdy_mode = 0;
        acc_cyc.delete();
        d0 = done_total;
        send_cmd(16'h0030, 3, 11'd1, t0);
        send_cmd(16'h0050, 5, 11'd2, t1);
        wait_idle("b2b", 400);
        check_int("b2b_done_count", done_total - d0, 2);
        check_int("b2b_beat_count", acc_cyc.size(), 10);
        if (acc_cyc.size() == 10) begin
            check_int("b2b_second_hs", t1, acc_cyc[3] + 1);
            check_int("b2b_second_hdr", acc_cyc[4], t1 + 2);
        end

        // Random commands under random backpressure.
        rdy_mode = 1;
        for (int k = 0; k < 4; k++) begin
            send_cmd(16'($urandom), int'($urandom_range(0, 40)), 11'($urandom), t0);
        end
        wait_idle("random", 4000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
